ipv4_hdr_partial_sum: RTL and testbench
=======================================

IPV4_HDR_PARTIAL_SUM -- requirements
Module: ipv4_hdr_partial_sum

Interface
REQ-001 SHALL have parameters: C_M_AXIS_DATA_WIDTH, default 256, master stream data width (only 256 supported); C_S_AXIS_DATA_WIDTH, default 256, slave stream data width; C_M_AXIS_TUSER_WIDTH, default 128, master TUSER width; C_S_AXIS_TUSER_WIDTH, default 128, slave TUSER width.
REQ-002 SHALL have ports:
  - AXI_ACLK  in  1  single clock, all logic on rising edge.
  - AXI_RESET  in  1  synchronous, active-high reset.
  - S_AXIS_TDATA/TSTRB/TUSER/TVALID/TLAST  in  256/32/128/1/1  input packet stream.
  - S_AXIS_TREADY  out  1  input backpressure.
  - M_AXIS_TDATA/TSTRB/TUSER/TVALID/TLAST  out  256/32/128/1/1  output packet stream.
  - M_AXIS_TREADY  in  1  output backpressure.
  - checksum01..checksum04  out  32 each  registered IPv4 header partial sums.
  - sum_valid  out  1  one-cycle pulse when sums load.
  - hdr_ok  out  1  registered: last loaded header is IPv4 with IHL=5.
  - pkt_count, bad_hdr_count  out  32 each  statistics counters.
REQ-003 SHALL use byte numbering in which packet byte k of a beat occupies TDATA[255-8k -: 8], and hw@k denotes the 16-bit big-endian halfword at bytes k,k+1.

Function
REQ-004 SHALL implement states IDLE, HDR1, EMIT0, EMIT1, PASS.
REQ-005 IDLE: S_AXIS_TREADY=1 and M_AXIS_TVALID=0; an S handshake captures the beat (data, strb, user, last) into hold0.
  - If that beat is not TLAST, go to HDR1.
  - If it is TLAST, load the sums with hw@32 taken as 0, force hdr_ok=0, and go to EMIT0.
REQ-006 HDR1: S_AXIS_TREADY=1 and M_AXIS_TVALID=0; an S handshake captures the beat into hold1, loads the sums, and goes to EMIT0.
REQ-007 Sum definitions, each a 32-bit register holding the zero-extended sum of 16-bit halfwords, with no end-around carry:
  - checksum01 = hw@14+hw@16+hw@18+hw@20 (beat 0).
  - checksum02 = hw@22+hw@24 (beat 0).
  - checksum03 = hw@26+hw@28 (beat 0).
  - checksum04 = hw@30 (beat 0) + hw@0 of beat 1, i.e. packet byte 32.
REQ-008 hdr_ok SHALL be 1 only when beat0 hw@12 == 0x0800, beat0 byte 14 == 0x45, and beat 1 exists.
REQ-009 Sum load SHALL update checksum01..04, hdr_ok and sum_valid=1 in the same registered cycle; sum_valid is 0 on all other cycles; the outputs hold until the next load.
REQ-010 EMIT0: S_AXIS_TREADY=0, M_AXIS_TVALID=1, M bus = hold0.
  - On M handshake: if hold0.last, go to IDLE; otherwise go to EMIT1.
REQ-011 EMIT1: S_AXIS_TREADY=0, M bus = hold1.
  - On M handshake: if hold1.last, go to IDLE; otherwise go to PASS.
REQ-012 PASS: M bus is driven combinationally from S, with M_AXIS_TVALID=S_AXIS_TVALID and S_AXIS_TREADY=M_AXIS_TREADY; a handshake with TLAST goes to IDLE.
REQ-013 SHALL hold M outputs stable while M_AXIS_TVALID=1 and M_AXIS_TREADY=0; SHALL never drop, duplicate or reorder beats.
REQ-014 Added latency: the first beat reaches M no earlier than 1 cycle after beat 1 is accepted; PASS adds 0 cycles.
REQ-015 pkt_count SHALL increment on every IDLE capture; bad_hdr_count SHALL increment on every sum load with hdr_ok=0; both wrap 0xFFFFFFFF->0.
REQ-016 A load and an increment in the same cycle SHALL both take effect.
REQ-017 Maximum sum value is 0x3FFFC; the upper 14 bits of each sum register SHALL remain 0.

Reset
REQ-018 While AXI_RESET=1:
  - State is IDLE.
  - checksum01..04, hdr_ok, sum_valid, pkt_count and bad_hdr_count are 0.
  - M_AXIS_TVALID=0 and S_AXIS_TREADY=0.
  - hold0 and hold1 are invalid.
REQ-019 SHALL accept S beats in the first cycle after AXI_RESET deasserts.
REQ-020 Reset mid-packet SHALL discard the held beats; the next S beat after reset is treated as a new packet's beat 0.

Verification
REQ-021 IPv4 header 4500 0073 0000 4000 4011 b861 c0a8 0001 c0a8 00c7, ethertype 0x0800, 3-beat packet -> checksum01=0x8573, checksum02=0xF872, checksum03=0xC0A9, checksum04=0xC16F, hdr_ok=1, one sum_valid pulse, 3 beats out unchanged, pkt_count=1.
REQ-022 ARP frame (ethertype 0x0806), 2 beats -> sums loaded, hdr_ok=0, bad_hdr_count=1, both beats emitted, FSM goes EMIT1->IDLE.
REQ-023 Single-beat packet with TLAST on beat 0 -> checksum04=hw@30 only, hdr_ok=0, 1 beat out with TLAST, FSM returns to IDLE.
REQ-024 M_AXIS_TREADY held 0 for 10 cycles during EMIT0, with random TREADY toggling in PASS -> M data stable while stalled; output beat sequence equals input; no S handshake during EMIT0/EMIT1.
REQ-025 AXI_RESET pulsed in PASS of a 5-beat packet, then a new valid IPv4 packet sent -> all outputs 0 during reset; the new packet's sums are correct and pkt_count=1.
REQ-026 pkt_count preloaded via force to 0xFFFFFFFF, then one packet sent -> pkt_count=0.

Source files
------------

// File: rtl/ipv4_hdr_partial_sum.sv
// ipv4_hdr_partial_sum: buffers the first two beats of each packet, emits IPv4 header partial sums, then forwards the stream unchanged
module ipv4_hdr_partial_sum #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128
) (
  input  logic                              AXI_ACLK,
  input  logic                              AXI_RESET,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    S_AXIS_TDATA,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_TSTRB,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   S_AXIS_TUSER,
  input  logic                              S_AXIS_TVALID,
  input  logic                              S_AXIS_TLAST,
  output logic                              S_AXIS_TREADY,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  M_AXIS_TSTRB,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
  output logic                              M_AXIS_TVALID,
  output logic                              M_AXIS_TLAST,
  input  logic                              M_AXIS_TREADY,
  output logic [31:0]                       checksum01,
  output logic [31:0]                       checksum02,
  output logic [31:0]                       checksum03,
  output logic [31:0]                       checksum04,
  output logic                              sum_valid,
  output logic                              hdr_ok,
  output logic [31:0]                       pkt_count,
  output logic [31:0]                       bad_hdr_count
);
  localparam int DW = C_S_AXIS_DATA_WIDTH;
  typedef enum logic [2:0] {IDLE, HDR1, EMIT0, EMIT1, PASS} state_t;
  state_t r_state, w_next;
  logic [DW-1:0]                     r_h0_data, r_h1_data, w_b0;
  logic [DW/8-1:0]                   r_h0_strb, r_h1_strb;
  logic [C_S_AXIS_TUSER_WIDTH-1:0]   r_h0_user, r_h1_user;
  logic                              r_h0_last, r_h1_last;
  logic [31:0]                       r_cs1, r_cs2, r_cs3, r_cs4, r_pkt_count, r_bad_count;
  logic                              r_sum_valid, r_hdr_ok;
  logic                              w_s_hs, w_m_hs, w_cap0, w_cap1, w_load, w_ok;
  logic [15:0]                       w_b1hw;
  // Big-endian halfword starting at byte k, byte 0 in the top bits
  function automatic logic [15:0] hw(input logic [DW-1:0] d, input int k);
    hw = d[DW-1-8*k -: 16];
  endfunction
  assign w_s_hs = S_AXIS_TVALID && S_AXIS_TREADY;
  assign w_m_hs = M_AXIS_TVALID && M_AXIS_TREADY;
  assign w_cap0 = w_s_hs && r_state == IDLE;
  assign w_cap1 = w_s_hs && r_state == HDR1;
  assign w_load = w_cap1 || (w_cap0 && S_AXIS_TLAST);
  // A single-beat packet loads straight from the bus with no beat 1
  assign w_b0   = r_state == IDLE ? S_AXIS_TDATA : r_h0_data;
  assign w_b1hw = r_state == IDLE ? 16'h0 : hw(S_AXIS_TDATA, 0);
  assign w_ok   = hw(w_b0, 12) == 16'h0800 && w_b0[DW-1-8*14 -: 8] == 8'h45 && r_state != IDLE;
  always_ff @(posedge AXI_ACLK) begin
    if (AXI_RESET) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  w_next = w_s_hs ? (S_AXIS_TLAST ? EMIT0 : HDR1) : IDLE;
      HDR1:  w_next = w_s_hs ? EMIT0 : HDR1;
      EMIT0: w_next = w_m_hs ? (r_h0_last ? IDLE : EMIT1) : EMIT0;
      EMIT1: w_next = w_m_hs ? (r_h1_last ? IDLE : PASS) : EMIT1;
      PASS:  w_next = (w_s_hs && S_AXIS_TLAST) ? IDLE : PASS;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    S_AXIS_TREADY = !AXI_RESET && (r_state == IDLE || r_state == HDR1 || (r_state == PASS && M_AXIS_TREADY));
    M_AXIS_TVALID = !AXI_RESET && (r_state == EMIT0 || r_state == EMIT1 || (r_state == PASS && S_AXIS_TVALID));
    M_AXIS_TDATA  = r_state == PASS ? S_AXIS_TDATA : (r_state == EMIT1 ? r_h1_data : r_h0_data);
    M_AXIS_TSTRB  = r_state == PASS ? S_AXIS_TSTRB : (r_state == EMIT1 ? r_h1_strb : r_h0_strb);
    M_AXIS_TUSER  = r_state == PASS ? S_AXIS_TUSER : (r_state == EMIT1 ? r_h1_user : r_h0_user);
    M_AXIS_TLAST  = r_state == PASS ? S_AXIS_TLAST : (r_state == EMIT1 ? r_h1_last : r_h0_last);
  end
  always_ff @(posedge AXI_ACLK) begin
    if (w_cap0) begin
      r_h0_data <= S_AXIS_TDATA;
      r_h0_strb <= S_AXIS_TSTRB;
      r_h0_user <= S_AXIS_TUSER;
      r_h0_last <= S_AXIS_TLAST;
    end
    if (w_cap1) begin
      r_h1_data <= S_AXIS_TDATA;
      r_h1_strb <= S_AXIS_TSTRB;
      r_h1_user <= S_AXIS_TUSER;
      r_h1_last <= S_AXIS_TLAST;
    end
  end
  always_ff @(posedge AXI_ACLK) begin
    if (AXI_RESET) begin
      r_cs1       <= '0;
      r_cs2       <= '0;
      r_cs3       <= '0;
      r_cs4       <= '0;
      r_hdr_ok    <= 1'b0;
      r_sum_valid <= 1'b0;
      r_pkt_count <= '0;
      r_bad_count <= '0;
    end else begin
      r_sum_valid <= w_load;
      if (w_load) begin
        r_cs1    <= 32'(hw(w_b0, 14)) + 32'(hw(w_b0, 16)) + 32'(hw(w_b0, 18)) + 32'(hw(w_b0, 20));
        r_cs2    <= 32'(hw(w_b0, 22)) + 32'(hw(w_b0, 24));
        r_cs3    <= 32'(hw(w_b0, 26)) + 32'(hw(w_b0, 28));
        r_cs4    <= 32'(hw(w_b0, 30)) + 32'(w_b1hw);
        r_hdr_ok <= w_ok;
        if (!w_ok) r_bad_count <= r_bad_count + 32'd1;
      end
      if (w_cap0) r_pkt_count <= r_pkt_count + 32'd1;
    end
  end
  assign checksum01    = r_cs1;
  assign checksum02    = r_cs2;
  assign checksum03    = r_cs3;
  assign checksum04    = r_cs4;
  assign sum_valid     = r_sum_valid;
  assign hdr_ok        = r_hdr_ok;
  assign pkt_count     = r_pkt_count;
  assign bad_hdr_count = r_bad_count;
endmodule

// File: tb/tb_ipv4_hdr_partial_sum.sv
// tb_ipv4_hdr_partial_sum: directed packets checked against a byte-level packet model and a beat scoreboard
module tb_ipv4_hdr_partial_sum;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic [255:0] s_data, m_data;
  logic [31:0]  s_strb, m_strb;
  logic [127:0] s_user, m_user;
  logic s_valid, s_last, s_ready, m_valid, m_last, m_ready, sum_valid, hdr_ok;
  logic [31:0] cs1, cs2, cs3, cs4, pkt_count, bad_count;

  ipv4_hdr_partial_sum dut (
    .AXI_ACLK(clk), .AXI_RESET(rst),
    .S_AXIS_TDATA(s_data), .S_AXIS_TSTRB(s_strb), .S_AXIS_TUSER(s_user),
    .S_AXIS_TVALID(s_valid), .S_AXIS_TLAST(s_last), .S_AXIS_TREADY(s_ready),
    .M_AXIS_TDATA(m_data), .M_AXIS_TSTRB(m_strb), .M_AXIS_TUSER(m_user),
    .M_AXIS_TVALID(m_valid), .M_AXIS_TLAST(m_last), .M_AXIS_TREADY(m_ready),
    .checksum01(cs1), .checksum02(cs2), .checksum03(cs3), .checksum04(cs4),
    .sum_valid(sum_valid), .hdr_ok(hdr_ok), .pkt_count(pkt_count), .bad_hdr_count(bad_count)
  );

  typedef struct {logic [255:0] d; logic [31:0] s; logic [127:0] u; logic l;} beat_t;
  typedef struct {logic [31:0] c1, c2, c3, c4; logic ok; logic [31:0] pc, bc;} sum_t;
  beat_t bq[$];
  sum_t  sq[$];
  int n_chk = 0, n_fail = 0, sv_cnt = 0, mode = 0, nb = 0;
  logic [7:0]   pkt [0:255];
  logic [159:0] iph = 160'h4500_0073_0000_4000_4011_b861_c0a8_0001_c0a8_00c7;
  logic [31:0]  m_pkt = 0, m_bad = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Packet = bytes; Ethernet header at 0..13, IPv4 header at 14..33
  task automatic build(input logic [15:0] et, input int nbeats, input logic [7:0] seed);
    nb = nbeats;
    for (int i = 0; i < 256; i++) pkt[i] = 8'(i * 7) + seed;
    pkt[12] = et[15:8];
    pkt[13] = et[7:0];
    for (int i = 0; i < 20; i++) pkt[14+i] = iph[159-8*i -: 8];
  endtask

  function automatic logic [31:0] phw(input int k);
    return {16'h0, pkt[k], pkt[k+1]};
  endfunction

  function automatic beat_t mk(input int b);
    beat_t bt;
    for (int k = 0; k < 32; k++) bt.d[255-8*k -: 8] = pkt[32*b+k];
    bt.l = (b == nb - 1);
    bt.s = bt.l ? 32'hFFFF_FF00 : 32'hFFFF_FFFF;
    bt.u = {32'(b), 32'(nb), bt.d[63:0]};
    return bt;
  endfunction

  task automatic send(input int first, input int last);
    beat_t bt;
    sum_t r;
    int t;
    if (first == 0) begin
      r.ok = pkt[12] == 8'h08 && pkt[13] == 8'h00 && pkt[14] == 8'h45 && nb > 1;
      m_pkt = m_pkt + 1;
      if (!r.ok) m_bad = m_bad + 1;
      r.c1 = phw(14) + phw(16) + phw(18) + phw(20);
      r.c2 = phw(22) + phw(24);
      r.c3 = phw(26) + phw(28);
      r.c4 = phw(30) + (nb > 1 ? phw(32) : 32'h0);
      r.pc = m_pkt;
      r.bc = m_bad;
      sq.push_back(r);
    end
    for (int b = first; b <= last; b++) begin
      bt = mk(b);
      @(posedge clk); #1;
      s_valid = 1'b1; s_data = bt.d; s_strb = bt.s; s_user = bt.u; s_last = bt.l;
      t = 0;
      while (1) begin
        @(negedge clk);
        if (s_ready) break;
        if (++t > 200) break;
      end
      chk("s_accept", 256'(s_ready), 256'(1));
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((bq.size() != 0 || !s_ready) && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("drain_beats", 256'(bq.size()), 256'(0));
    chk("drain_sums", 256'(sq.size()), 256'(0));
    @(negedge clk);
  endtask

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_ready = mode == 2 ? 1'($urandom) : (mode == 0);
    end
  end

  // Scoreboard: every accepted S beat must appear on M in order; every sum pulse must match the model
  logic stall = 1'b0;
  beat_t sb;
  always @(negedge clk) begin
    if (rst) begin
      bq.delete();
      sq.delete();
      stall = 1'b0;
    end else begin
      if (s_valid && s_ready) bq.push_back('{s_data, s_strb, s_user, s_last});
      if (stall) begin
        chk("stall_valid", 256'(m_valid), 256'(1));
        chk("stall_data", m_data, sb.d);
        chk("stall_last", 256'(m_last), 256'(sb.l));
      end
      if (m_valid && m_ready) begin
        chk("m_beat_pending", 256'(bq.size() != 0), 256'(1));
        if (bq.size() != 0) begin
          sb = bq.pop_front();
          chk("m_data", m_data, sb.d);
          chk("m_strb", 256'(m_strb), 256'(sb.s));
          chk("m_user", 256'(m_user), 256'(sb.u));
          chk("m_last", 256'(m_last), 256'(sb.l));
        end
      end
      stall = m_valid && !m_ready;
      sb = '{m_data, m_strb, m_user, m_last};
      if (sum_valid) begin
        sum_t r;
        sv_cnt++;
        chk("sum_pending", 256'(sq.size() != 0), 256'(1));
        if (sq.size() != 0) begin
          r = sq.pop_front();
          chk("cs01", 256'(cs1), 256'(r.c1));
          chk("cs02", 256'(cs2), 256'(r.c2));
          chk("cs03", 256'(cs3), 256'(r.c3));
          chk("cs04", 256'(cs4), 256'(r.c4));
          chk("hdr_ok", 256'(hdr_ok), 256'(r.ok));
          chk("pkt_count", 256'(pkt_count), 256'(r.pc));
          chk("bad_count", 256'(bad_count), 256'(r.bc));
        end
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_cs01"}, 256'(cs1), 256'(0));
    chk({tag, "_cs02"}, 256'(cs2), 256'(0));
    chk({tag, "_cs03"}, 256'(cs3), 256'(0));
    chk({tag, "_cs04"}, 256'(cs4), 256'(0));
    chk({tag, "_hdr_ok"}, 256'(hdr_ok), 256'(0));
    chk({tag, "_sum_valid"}, 256'(sum_valid), 256'(0));
    chk({tag, "_pkt_count"}, 256'(pkt_count), 256'(0));
    chk({tag, "_bad_count"}, 256'(bad_count), 256'(0));
    chk({tag, "_m_valid"}, 256'(m_valid), 256'(0));
    chk({tag, "_s_ready"}, 256'(s_ready), 256'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    s_valid = 1'b0; s_last = 1'b0; s_data = '0; s_strb = '0; s_user = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 256'(s_ready), 256'(1));
    // 3-beat IPv4 packet, worked example
    build(16'h0800, 3, 8'h10);
    send(0, 2);
    drain();
    chk("ipv4_cs01", 256'(cs1), 256'(32'h8573));
    chk("ipv4_cs02", 256'(cs2), 256'(32'hF872));
    chk("ipv4_cs03", 256'(cs3), 256'(32'hC0A9));
    chk("ipv4_cs04", 256'(cs4), 256'(32'hC16F));
    chk("ipv4_hdr_ok", 256'(hdr_ok), 256'(1));
    chk("ipv4_pkt_count", 256'(pkt_count), 256'(1));
    chk("ipv4_sum_pulses", 256'(sv_cnt), 256'(1));
    // 2-beat ARP frame
    build(16'h0806, 2, 8'h20);
    send(0, 1);
    drain();
    chk("arp_hdr_ok", 256'(hdr_ok), 256'(0));
    chk("arp_bad_count", 256'(bad_count), 256'(1));
    chk("arp_idle", 256'(s_ready), 256'(1));
    // single-beat packet: no byte 32
    build(16'h0800, 1, 8'h30);
    send(0, 0);
    drain();
    chk("single_cs04", 256'(cs4), 256'(32'hC0A8));
    chk("single_hdr_ok", 256'(hdr_ok), 256'(0));
    chk("single_pkt_count", 256'(pkt_count), 256'(3));
    chk("single_idle", 256'(s_ready), 256'(1));
    // stall EMIT0 for 10 cycles, then random ready through PASS
    mode = 1;
    @(posedge clk); #1;
    build(16'h0800, 6, 8'h40);
    send(0, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_s_ready", 256'(s_ready), 256'(0));
      chk("stall_m_valid", 256'(m_valid), 256'(1));
      chk("stall_beat0", m_data, mk(0).d);
    end
    mode = 2;
    send(2, 5);
    drain();
    mode = 0;
    // reset while in PASS of a 5-beat packet
    build(16'h0800, 5, 8'h50);
    send(0, 2);
    rst = 1'b1;
    m_pkt = 0;
    m_bad = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("midreset");
    @(posedge clk); #1;
    rst = 1'b0;
    build(16'h0800, 3, 8'h60);
    send(0, 2);
    drain();
    chk("after_reset_pkt_count", 256'(pkt_count), 256'(1));
    chk("after_reset_cs01", 256'(cs1), 256'(32'h8573));
    chk("after_reset_hdr_ok", 256'(hdr_ok), 256'(1));
    // counter wrap
    @(posedge clk); #1;
    force dut.r_pkt_count = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut.r_pkt_count;
    m_pkt = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("preload_pkt_count", 256'(pkt_count), 256'(32'hFFFF_FFFF));
    build(16'h0800, 2, 8'h70);
    send(0, 1);
    drain();
    chk("wrap_pkt_count", 256'(pkt_count), 256'(0));
    chk("total_sum_pulses", 256'(sv_cnt), 256'(7));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
